// File: rtl/unidad_riesgos_pkg.sv
// Shared types for the hazard unit: execution-unit codes, divider FSM states, register-id width.
// Pure declarations; no latency or backpressure of its own.
package unidad_riesgos_pkg;

   localparam int RID_W = 4;

   typedef enum logic [1:0] {
      UNIT_ALU = 2'd0,
      UNIT_LD  = 2'd1,
      UNIT_MUL = 2'd2,
      UNIT_DIV = 2'd3
   } unit_e;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_state_e;

endpackage

// File: rtl/unidad_riesgos_if.sv
// Decode/completion bundle between the pipeline (master) and the hazard unit (slave).
// Wires only; stall is the backpressure signal back to decode.
interface unidad_riesgos_if #(
   parameter int NREG = 16
);
   import unidad_riesgos_pkg::*;

   logic             id_valid;
   unit_e            id_unit;
   logic             id_we;
   logic [RID_W-1:0] id_rd;
   logic [RID_W-1:0] id_rs1;
   logic [RID_W-1:0] id_rs2;
   logic             id_use_rs1;
   logic             id_use_rs2;
   logic             alu_done;
   logic [RID_W-1:0] alu_Rd;
   logic             ld_done;
   logic [RID_W-1:0] ld_Rd;
   logic             div_done;
   logic             stall;
   logic             issue;
   logic             div_start;
   logic             mul_done;
   logic [RID_W-1:0] mul_Rd;
   logic [RID_W-1:0] div_Rd;
   logic [NREG-1:0]  pending;

   modport master (
      output id_valid, id_unit, id_we, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             alu_done, alu_Rd, ld_done, ld_Rd, div_done,
      input  stall, issue, div_start, mul_done, mul_Rd, div_Rd, pending
   );

   modport slave (
      input  id_valid, id_unit, id_we, id_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
             alu_done, alu_Rd, ld_done, ld_Rd, div_done,
      output stall, issue, div_start, mul_done, mul_Rd, div_Rd, pending
   );

endinterface

// File: rtl/unidad_riesgos_mul_latency_pipe.sv
// Tracks in-flight multiplies: valid/we/rd shift register, out exactly MUL_LAT cycles after in.
// No backpressure; accepts one entry per cycle.
module mul_latency_pipe
   import unidad_riesgos_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_vld,
   input  logic             in_we,
   input  logic [RID_W-1:0] in_rd,
   output logic             out_vld,
   output logic             out_we,
   output logic [RID_W-1:0] out_rd
);

   logic [MUL_LAT-1:0] vld_q, vld_d;
   logic [MUL_LAT-1:0] we_q, we_d;
   logic [RID_W-1:0]   rd_q [MUL_LAT];
   logic [RID_W-1:0]   rd_d [MUL_LAT];

   always_comb begin
      vld_d    = '0;
      we_d     = '0;
      vld_d[0] = in_vld;
      we_d[0]  = in_vld && in_we;
      rd_d[0]  = in_vld ? in_rd : '0;
      for (int i = 1; i < MUL_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         we_d[i]  = we_q[i-1];
         rd_d[i]  = rd_q[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         we_q  <= '0;
         for (int i = 0; i < MUL_LAT; i++) rd_q[i] <= '0;
      end else begin
         vld_q <= vld_d;
         we_q  <= we_d;
         for (int i = 0; i < MUL_LAT; i++) rd_q[i] <= rd_d[i];
      end
   end

   assign out_vld = vld_q[MUL_LAT-1];
   assign out_we  = we_q[MUL_LAT-1];
   assign out_rd  = rd_q[MUL_LAT-1];

endmodule

// File: rtl/unidad_riesgos.sv
// Register scoreboard + RAW/WAW/structural hazard detection + divider FSM; stall/issue are combinational.
// Backpressure: stall holds decode; completions free registers at the next edge.
module unidad_riesgos
   import unidad_riesgos_pkg::*;
#(
   parameter int MUL_LAT = 3,
   parameter int NREG    = 16
) (
   input  logic clk,
   input  logic rst,
   unidad_riesgos_if.slave bus
);

   function automatic logic [NREG-1:0] onehot(input logic [RID_W-1:0] id);
      logic [NREG-1:0] v;
      for (int i = 0; i < NREG; i++) v[i] = (id == RID_W'(i));
      return v;
   endfunction

   div_state_e       div_state_q, div_state_d;
   logic [RID_W-1:0] div_rd_q, div_rd_d;
   logic             div_we_q, div_we_d;
   logic [NREG-1:0]  pending_q, pending_d;
   logic [NREG-1:0]  clr;
   logic             raw1, raw2, waw, struct_h;
   logic             stall, issue;
   logic             mul_vld, mul_we;
   logic [RID_W-1:0] mul_rd;

   always_comb begin
      clr = '0;
      if (bus.alu_done)    clr = clr | onehot(bus.alu_Rd);
      if (bus.ld_done)     clr = clr | onehot(bus.ld_Rd);
      if (mul_vld && mul_we) clr = clr | onehot(mul_rd);
      // A div_done seen while IDLE belongs to an abandoned operation.
      if (bus.div_done && div_state_q == DIV_BUSY && div_we_q)
         clr = clr | onehot(div_rd_q);

      raw1     = bus.id_use_rs1 && (|(pending_q & ~clr & onehot(bus.id_rs1)));
      raw2     = bus.id_use_rs2 && (|(pending_q & ~clr & onehot(bus.id_rs2)));
      waw      = bus.id_we && (|(pending_q & onehot(bus.id_rd)));
      struct_h = (bus.id_unit == UNIT_DIV) && (div_state_q == DIV_BUSY);
      stall    = bus.id_valid && (raw1 || raw2 || waw || struct_h);
      issue    = bus.id_valid && !stall;

      pending_d = pending_q & ~clr;
      if (issue && bus.id_we) pending_d = pending_d | onehot(bus.id_rd);

      div_state_d = div_state_q;
      div_rd_d    = div_rd_q;
      div_we_d    = div_we_q;
      case (div_state_q)
         DIV_IDLE: if (issue && bus.id_unit == UNIT_DIV) begin
            div_state_d = DIV_BUSY;
            div_rd_d    = bus.id_rd;
            div_we_d    = bus.id_we;
         end
         DIV_BUSY: if (bus.div_done) div_state_d = DIV_IDLE;
         default:  div_state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_state_q <= DIV_IDLE;
         div_rd_q    <= '0;
         div_we_q    <= 1'b0;
         pending_q   <= '0;
      end else begin
         div_state_q <= div_state_d;
         div_rd_q    <= div_rd_d;
         div_we_q    <= div_we_d;
         pending_q   <= pending_d;
      end
   end

   mul_latency_pipe #(.MUL_LAT(MUL_LAT)) u_mul_pipe (
      .clk     (clk),
      .rst     (rst),
      .in_vld  (issue && bus.id_unit == UNIT_MUL),
      .in_we   (bus.id_we),
      .in_rd   (bus.id_rd),
      .out_vld (mul_vld),
      .out_we  (mul_we),
      .out_rd  (mul_rd)
   );

   assign bus.stall     = stall;
   assign bus.issue     = issue;
   assign bus.div_start = issue && (bus.id_unit == UNIT_DIV) && !rst;
   assign bus.mul_done  = mul_vld;
   assign bus.mul_Rd    = mul_rd;
   assign bus.div_Rd    = div_rd_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_unidad_riesgos.sv
// Directed, table-driven check of unidad_riesgos with MUL_LAT=3, NREG=16.
module tb_unidad_riesgos;
   import unidad_riesgos_pkg::*;

   typedef struct {
      logic v; logic [1:0] unit; logic we; logic [3:0] rd;
      logic [3:0] rs1; logic u1; logic [3:0] rs2; logic u2;
      logic ad; logic [3:0] ard; logic ldn; logic [3:0] lrd; logic dd;
   } in_t;

   typedef struct {
      logic st; logic is; logic [15:0] pend;
      logic md; logic [3:0] mrd; logic ds; logic [3:0] drd;
   } ex_t;

   typedef struct { in_t i; ex_t e; } vec_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   vec_t tbl[$];

   unidad_riesgos_if #(.NREG(16)) bus ();

   unidad_riesgos #(.MUL_LAT(3), .NREG(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic in_t fi(int v, int unit, int we, int rd, int rs1, int u1, int rs2, int u2,
                              int ad, int ard, int ldn, int lrd, int dd);
      in_t x;
      x.v = v[0]; x.unit = unit[1:0]; x.we = we[0]; x.rd = rd[3:0];
      x.rs1 = rs1[3:0]; x.u1 = u1[0]; x.rs2 = rs2[3:0]; x.u2 = u2[0];
      x.ad = ad[0]; x.ard = ard[3:0]; x.ldn = ldn[0]; x.lrd = lrd[3:0]; x.dd = dd[0];
      return x;
   endfunction

   function automatic ex_t fe(int st, int is, int pend, int md, int mrd, int ds, int drd);
      ex_t x;
      x.st = st[0]; x.is = is[0]; x.pend = pend[15:0];
      x.md = md[0]; x.mrd = mrd[3:0]; x.ds = ds[0]; x.drd = drd[3:0];
      return x;
   endfunction

   task automatic add(input in_t i, input ex_t e);
      vec_t t;
      t.i = i;
      t.e = e;
      tbl.push_back(t);
   endtask

   task automatic drive(input in_t x);
      bus.id_valid   = x.v;
      bus.id_unit    = unit_e'(x.unit);
      bus.id_we      = x.we;
      bus.id_rd      = x.rd;
      bus.id_rs1     = x.rs1;
      bus.id_use_rs1 = x.u1;
      bus.id_rs2     = x.rs2;
      bus.id_use_rs2 = x.u2;
      bus.alu_done   = x.ad;
      bus.alu_Rd     = x.ard;
      bus.ld_done    = x.ldn;
      bus.ld_Rd      = x.lrd;
      bus.div_done   = x.dd;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   in_t idle;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      idle  = fi(0,0,0,0, 0,0,0,0, 0,0,0,0,0);

      // v unit we rd  rs1 u1 rs2 u2  ad ard ld lrd dd  |  st is pend md mrd ds drd
      add(fi(1,0,1,3, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,0));  // 0 ALU r3
      add(fi(1,0,1,1, 3,1,0,0, 1,3,0,0,0),   fe(0,1,16'h0008,0,0,0,0));  // 1 reads r3, forwarded
      add(idle,                              fe(0,0,16'h0002,0,0,0,0));
      add(fi(0,0,0,0, 0,0,0,0, 1,1,0,0,0),   fe(0,0,16'h0002,0,0,0,0));
      add(fi(1,0,1,4, 0,0,0,0, 1,4,0,0,0),   fe(0,1,16'h0000,0,0,0,0));  // 4 set beats clear
      add(idle,                              fe(0,0,16'h0010,0,0,0,0));
      add(fi(0,0,0,0, 0,0,0,0, 1,4,0,0,0),   fe(0,0,16'h0010,0,0,0,0));
      add(fi(1,2,1,5, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,0));  // 7 MUL r5
      add(fi(1,0,1,6, 5,1,0,0, 0,0,0,0,0),   fe(1,0,16'h0020,0,0,0,0));
      add(fi(1,0,1,6, 5,1,0,0, 0,0,0,0,0),   fe(1,0,16'h0020,0,0,0,0));
      add(fi(1,0,1,6, 5,1,0,0, 0,0,0,0,0),   fe(0,1,16'h0020,1,5,0,0));  // 10 mul_done r5
      add(idle,                              fe(0,0,16'h0040,0,0,0,0));
      add(fi(0,0,0,0, 0,0,0,0, 1,6,0,0,0),   fe(0,0,16'h0040,0,0,0,0));
      add(fi(1,3,1,7, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,1,0));  // 13 DIV r7
      add(fi(1,3,1,8, 0,0,0,0, 0,0,0,0,0),   fe(1,0,16'h0080,0,0,0,7));
      add(fi(1,3,1,8, 0,0,0,0, 0,0,0,0,1),   fe(1,0,16'h0080,0,0,0,7));  // 15 busy despite div_done
      add(fi(1,3,1,8, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,1,7));
      add(idle,                              fe(0,0,16'h0100,0,0,0,8));
      add(fi(0,0,0,0, 0,0,0,0, 0,0,0,0,1),   fe(0,0,16'h0100,0,0,0,8));
      add(fi(1,1,1,2, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,8));  // 19 LD r2
      add(fi(1,0,1,2, 0,0,0,0, 0,0,0,0,0),   fe(1,0,16'h0004,0,0,0,8));  // WAW
      add(fi(1,0,1,2, 0,0,0,0, 0,0,1,2,0),   fe(1,0,16'h0004,0,0,0,8));
      add(fi(1,0,1,2, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,8));
      add(idle,                              fe(0,0,16'h0004,0,0,0,8));
      add(fi(0,0,0,0, 0,0,0,0, 1,2,0,0,0),   fe(0,0,16'h0004,0,0,0,8));
      add(fi(1,2,0,9, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,8));  // 25 MUL, no write
      add(idle,                              fe(0,0,16'h0000,0,0,0,8));
      add(idle,                              fe(0,0,16'h0000,0,0,0,8));
      add(idle,                              fe(0,0,16'h0000,1,9,0,8));
      add(fi(1,1,1,10, 0,0,0,0, 0,0,0,0,0),  fe(0,1,16'h0000,0,0,0,8));  // 29 LD r10
      add(fi(1,0,1,11, 0,0,10,1, 0,0,0,0,0), fe(1,0,16'h0400,0,0,0,8));  // RAW on rs2
      add(fi(1,0,1,11, 0,0,10,1, 0,0,1,10,0),fe(0,1,16'h0400,0,0,0,8));
      add(fi(1,0,0,0, 0,1,11,0, 0,0,0,0,0),  fe(0,1,16'h0800,0,0,0,8));  // unused rs2 ignored
      add(fi(0,0,0,0, 0,0,0,0, 1,11,0,0,0),  fe(0,0,16'h0800,0,0,0,8));
      add(fi(1,0,1,8, 0,0,0,0, 0,0,0,0,0),   fe(0,1,16'h0000,0,0,0,8));  // 34 ALU r8
      add(fi(0,0,0,0, 0,0,0,0, 0,0,0,0,1),   fe(0,0,16'h0100,0,0,0,8));  // div_done while IDLE
      add(fi(0,0,0,0, 0,0,0,0, 1,8,0,0,0),   fe(0,0,16'h0100,0,0,0,8));
      add(idle,                              fe(0,0,16'h0000,0,0,0,8));

      // Reset state and combinational behaviour while held in reset.
      rst = 1'b1;
      drive(idle);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst pending",   32'(bus.pending),   32'h0);
      chk("rst mul_done",  32'(bus.mul_done),  32'h0);
      chk("rst mul_Rd",    32'(bus.mul_Rd),    32'h0);
      chk("rst div_Rd",    32'(bus.div_Rd),    32'h0);
      chk("rst stall",     32'(bus.stall),     32'h0);
      chk("rst issue",     32'(bus.issue),     32'h0);
      drive(fi(1,3,1,5, 5,1,0,0, 0,0,0,0,0));
      #1;
      chk("rst div stall",     32'(bus.stall),     32'h0);
      chk("rst div issue",     32'(bus.issue),     32'h1);
      chk("rst div_start",     32'(bus.div_start), 32'h0);
      @(posedge clk);
      #1;
      chk("rst hold pending",  32'(bus.pending),   32'h0);
      drive(idle);
      rst = 1'b0;

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].i);
         @(negedge clk);
         chk($sformatf("v%0d stall", k),     32'(bus.stall),     32'(tbl[k].e.st));
         chk($sformatf("v%0d issue", k),     32'(bus.issue),     32'(tbl[k].e.is));
         chk($sformatf("v%0d pending", k),   32'(bus.pending),   32'(tbl[k].e.pend));
         chk($sformatf("v%0d mul_done", k),  32'(bus.mul_done),  32'(tbl[k].e.md));
         chk($sformatf("v%0d div_start", k), 32'(bus.div_start), 32'(tbl[k].e.ds));
         chk($sformatf("v%0d div_Rd", k),    32'(bus.div_Rd),    32'(tbl[k].e.drd));
         if (tbl[k].e.md)
            chk($sformatf("v%0d mul_Rd", k), 32'(bus.mul_Rd),    32'(tbl[k].e.mrd));
         @(posedge clk);
         #1;
      end

      // Reset in the middle of a divide abandons it.
      drive(fi(1,3,1,9, 0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk("mid div issue",     32'(bus.issue),     32'h1);
      chk("mid div_start",     32'(bus.div_start), 32'h1);
      @(posedge clk);
      #1;
      drive(idle);
      @(negedge clk);
      chk("mid pending9",      32'(bus.pending),   32'h0200);
      chk("mid div_Rd",        32'(bus.div_Rd),    32'h9);
      #2;
      rst = 1'b1;
      #1;
      chk("mid rst pending",   32'(bus.pending),   32'h0);
      chk("mid rst div_Rd",    32'(bus.div_Rd),    32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(fi(1,3,0,0, 0,0,0,0, 0,0,0,0,0));
      #1;
      chk("post rst div stall", 32'(bus.stall),    32'h0);
      drive(idle);
      @(posedge clk);
      #1;
      drive(fi(1,0,1,9, 0,0,0,0, 0,0,0,0,0));
      @(negedge clk);
      chk("post rst alu issue", 32'(bus.issue),    32'h1);
      @(posedge clk);
      #1;
      drive(fi(0,0,0,0, 0,0,0,0, 0,0,0,0,1));
      @(negedge clk);
      chk("stale div_done pre",  32'(bus.pending), 32'h0200);
      @(posedge clk);
      #1;
      drive(idle);
      @(negedge clk);
      chk("stale div_done post", 32'(bus.pending), 32'h0200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
